// File: rtl/conv_viterbi_dec_core.sv
// Hard-decision Viterbi decoder for the rate-1/2, K=5 convolutional code on the 8-bit io harness.
// Register-exchange survivors; a frame ends when sym_valid drops, after which the held-back bits are flushed.
module conv_viterbi_dec_core #(
  parameter logic [4:0] POLY_1 = 5'b10111,
  parameter logic [4:0] POLY_2 = 5'b11001,
  parameter int         DEPTH  = 16,
  parameter int         PM_W   = 6
) (
  input  logic [7:0] io_in,
  output logic [7:0] io_out
);

  localparam int NS    = 16;
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int IDX_W = $clog2(DEPTH);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [PM_W-1:0]  PM_INIT  = {1'b1, {(PM_W-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, RUN, FLUSH} state_t;

  logic       clk;
  logic       rst_n;
  logic       sym_valid;
  logic [1:0] sym;
  logic       unused_io;

  assign clk       = io_in[0];
  assign rst_n     = io_in[1];
  assign sym_valid = io_in[2];
  assign sym       = {io_in[4], io_in[3]};
  assign unused_io = ^io_in[7:5];

  function automatic logic [1:0] exp_sym(input logic d, input logic [3:0] s);
    logic [4:0] reg5;
    reg5 = {d, s};
    return {^(reg5 & POLY_1), ^(reg5 & POLY_2)};
  endfunction

  function automatic logic [1:0] hamming(input logic [1:0] a, input logic [1:0] b);
    logic [1:0] x;
    x = a ^ b;
    return {1'b0, x[1]} + {1'b0, x[0]};
  endfunction

  function automatic logic [PM_W-1:0] sat_add(input logic [PM_W-1:0] a, input logic [1:0] b);
    logic [PM_W:0] s;
    s = {1'b0, a} + {{(PM_W-1){1'b0}}, b};
    return s[PM_W] ? {PM_W{1'b1}} : s[PM_W-1:0];
  endfunction

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [3:0]       best;
  logic [3:0]       best_l;
  logic [PM_W-1:0]  min_pm;
  logic [PM_W-1:0]  pm       [NS];
  logic [PM_W-1:0]  pm_nxt   [NS];
  logic [DEPTH-1:0] surv     [NS];
  logic [DEPTH-1:0] surv_nxt [NS];
  logic [IDX_W-1:0] fidx;
  logic             acs_en;
  logic             reinit;
  logic             dec_bit;
  logic             dec_valid;
  logic             busy;

  // Minimum metric and its lowest-index owner, both taken before the update.
  always_comb begin
    min_pm = pm[0];
    best   = 4'd0;
    for (int i = 1; i < NS; i++) begin
      if (pm[i] < min_pm) begin
        min_pm = pm[i];
        best   = 4'(i);
      end
    end
  end

  for (genvar g = 0; g < NS; g++) begin : g_acs
    localparam logic [3:0] NXT  = 4'(g);
    localparam logic [3:0] PRV0 = {NXT[2:0], 1'b0};
    localparam logic [3:0] PRV1 = {NXT[2:0], 1'b1};
    logic [PM_W-1:0]  cand0;
    logic [PM_W-1:0]  cand1;
    logic             take1;
    logic [DEPTH-1:0] surv_sel;

    assign cand0       = sat_add(pm[PRV0], hamming(sym, exp_sym(NXT[3], PRV0)));
    assign cand1       = sat_add(pm[PRV1], hamming(sym, exp_sym(NXT[3], PRV1)));
    assign take1       = cand1 < cand0;
    assign pm_nxt[g]   = (take1 ? cand1 : cand0) - min_pm;
    assign surv_sel    = take1 ? surv[PRV1] : surv[PRV0];
    assign surv_nxt[g] = {surv_sel[DEPTH-2:0], NXT[3]};
  end

  assign acs_en = sym_valid && (state == IDLE || state == RUN);
  assign reinit = (state == FLUSH) && (cnt == CNT_ONE);
  assign fidx   = IDX_W'(cnt - CNT_ONE);

  // Metrics and survivors return to the known-start-state pattern on reset and after every flush.
  always_ff @(posedge clk) begin
    for (int i = 0; i < NS; i++) begin
      if (!rst_n || reinit) begin
        pm[i]   <= (i == 0) ? '0 : PM_INIT;
        surv[i] <= '0;
      end else if (acs_en) begin
        pm[i]   <= pm_nxt[i];
        surv[i] <= surv_nxt[i];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      best_l    <= '0;
      dec_bit   <= 1'b0;
      dec_valid <= 1'b0;
      busy      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          dec_valid <= 1'b0;
          if (sym_valid) begin
            cnt   <= CNT_ONE;
            state <= RUN;
          end
        end
        RUN: begin
          if (sym_valid) begin
            dec_valid <= (cnt == CNT_FULL);
            if (cnt == CNT_FULL) dec_bit <= surv[best][DEPTH-1];
            else                 cnt     <= cnt + CNT_ONE;
          end else begin
            dec_valid <= 1'b0;
            if (cnt != '0) begin
              best_l <= best;
              busy   <= 1'b1;
              state  <= FLUSH;
            end else begin
              state <= IDLE;
            end
          end
        end
        FLUSH: begin
          // cnt doubles as the read pointer, walking from the oldest held bit down to the newest.
          dec_bit   <= surv[best_l][fidx];
          dec_valid <= 1'b1;
          cnt       <= cnt - CNT_ONE;
          if (cnt == CNT_ONE) begin
            busy  <= 1'b0;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign io_out = {5'b00000, busy, dec_valid, dec_bit};

endmodule

// File: tb/tb_conv_viterbi_dec_core.sv
// Bench for conv_viterbi_dec_core: frames are encoded from a polynomial-level encoder model,
// optionally corrupted, and the decoded stream is expected to reproduce the payload bits.
module tb_conv_viterbi_dec_core;

  localparam int DEPTH = 16;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       sym_valid;
  logic [1:0] sym;
  logic [2:0] junk;
  logic [7:0] io_in;
  logic [7:0] io_out;

  assign io_in = {junk, sym[1], sym[0], sym_valid, rst_n, clk};

  conv_viterbi_dec_core dut (
    .io_in  (io_in),
    .io_out (io_out)
  );

  always #5 clk = ~clk;

  int vectors     = 0;
  int miscompares = 0;
  int cyc         = 0;
  int busy_cnt    = 0;

  bit         pay[$];
  logic [1:0] syms[$];
  bit         expq[$];
  bit         outq[$];
  int         out_cyc[$];
  int         sym_cyc[$];
  bit [4:0]   g1 = 5'b10111;
  bit [4:0]   g2 = 5'b11001;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (io_out[1] === 1'b1) begin
      outq.push_back(io_out[0]);
      out_cyc.push_back(cyc);
    end
    if (io_out[2] === 1'b1) busy_cnt++;
  end

  task automatic clear_capture();
    outq.delete();
    out_cyc.delete();
    expq.delete();
    busy_cnt = 0;
  endtask

  // mode 0: random bits, 1: all zeros, 2: all ones
  task automatic make_payload(input int n, input int mode);
    pay.delete();
    for (int i = 0; i < n; i++) begin
      bit b;
      b = (mode == 0) ? 1'($urandom_range(0, 1)) : (mode == 2);
      pay.push_back(b);
    end
  endtask

  // Encoder from the generator definition: tap k of a polynomial (MSB first) sees the input k bits ago.
  task automatic encode();
    syms.delete();
    for (int n = 0; n < pay.size(); n++) begin
      bit s1 = 1'b0;
      bit s0 = 1'b0;
      for (int k = 0; k < 5; k++) begin
        bit x;
        x = (n >= k) ? pay[n-k] : 1'b0;
        if (g1[4-k]) s1 ^= x;
        if (g2[4-k]) s0 ^= x;
      end
      syms.push_back({s1, s0});
      expq.push_back(pay[n]);
    end
  endtask

  task automatic add_errors();
    int pos;
    pos = $urandom_range(2, 11);
    while (pos < int'(syms.size()) - 20) begin
      logic [1:0] m;
      m = ($urandom_range(0, 1) == 1) ? 2'b10 : 2'b01;
      syms[pos] = syms[pos] ^ m;
      pos += $urandom_range(12, 20);
    end
  endtask

  task automatic send_frame();
    sym_cyc.delete();
    for (int i = 0; i < syms.size(); i++) begin
      sym_valid = 1'b1;
      sym       = syms[i];
      junk      = 3'($urandom);
      sym_cyc.push_back(cyc);
      @(posedge clk);
      #1;
    end
    sym_valid = 1'b0;
    sym       = 2'($urandom);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; sym_valid = 1'b1; sym = 2'b11; junk = 3'b000;
    repeat (3) @(posedge clk);
    #1;
    vectors++;
    if (io_out !== 8'h00) begin
      miscompares++;
      $display("FAIL reset_outputs: got %b want 00000000", io_out);
    end
    rst_n = 1'b1; sym_valid = 1'b0;
    idle(2);
  endtask

  task automatic test_all_zero();
    int first;
    int nrun;
    clear_capture();
    make_payload(20, 1);
    encode();
    send_frame();
    idle(DEPTH + 6);
    vectors++;
    if (outq.size() != expq.size()) begin
      miscompares++;
      $display("FAIL zero_count: got %0d bits want %0d", outq.size(), expq.size());
    end
    for (int i = 0; i < expq.size() && i < outq.size(); i++) begin
      vectors++;
      if (outq[i] !== expq[i]) begin
        miscompares++;
        $display("FAIL zero_bit[%0d]: got %0d want %0d", i, outq[i], expq[i]);
      end
    end
    first = (out_cyc.size() > 0) ? out_cyc[0] : -1;
    vectors++;
    if (first != sym_cyc[DEPTH] + 1) begin
      miscompares++;
      $display("FAIL zero_latency: first valid at cycle %0d want %0d", first, sym_cyc[DEPTH] + 1);
    end
    nrun = 0;
    foreach (out_cyc[i]) if (out_cyc[i] <= sym_cyc[19] + 1) nrun++;
    vectors++;
    if (nrun != 4) begin
      miscompares++;
      $display("FAIL zero_run_bits: got %0d want 4", nrun);
    end
    vectors++;
    if (busy_cnt != DEPTH) begin
      miscompares++;
      $display("FAIL zero_busy_cycles: got %0d want %0d", busy_cnt, DEPTH);
    end
    vectors++;
    if (io_out[7:2] !== 6'b000000) begin
      miscompares++;
      $display("FAIL zero_idle_out: got %b want 000000", io_out[7:2]);
    end
  endtask

  task automatic test_impulse(input bit corrupt);
    clear_capture();
    make_payload(20, 1);
    pay[0] = 1'b1;
    encode();
    if (corrupt) syms[2] = 2'b00;
    send_frame();
    idle(DEPTH + 6);
    vectors++;
    if (outq.size() != expq.size()) begin
      miscompares++;
      $display("FAIL impulse%0d_count: got %0d bits want %0d", corrupt, outq.size(), expq.size());
    end
    for (int i = 0; i < expq.size() && i < outq.size(); i++) begin
      vectors++;
      if (outq[i] !== expq[i]) begin
        miscompares++;
        $display("FAIL impulse%0d_bit[%0d]: got %0d want %0d", corrupt, i, outq[i], expq[i]);
      end
    end
  endtask

  task automatic test_random();
    for (int f = 0; f < 2; f++) begin
      clear_capture();
      make_payload(64, 0);
      encode();
      if (f == 1) add_errors();
      send_frame();
      idle(DEPTH + 8);
      vectors++;
      if (outq.size() != 64) begin
        miscompares++;
        $display("FAIL random%0d_count: got %0d bits want 64", f, outq.size());
      end
      for (int i = 0; i < expq.size() && i < outq.size(); i++) begin
        vectors++;
        if (outq[i] !== expq[i]) begin
          miscompares++;
          $display("FAIL random%0d_bit[%0d]: got %0d want %0d", f, i, outq[i], expq[i]);
        end
      end
    end
  endtask

  task automatic test_short_frame();
    int first;
    clear_capture();
    make_payload(5, 1);
    pay[0] = 1'b1;
    encode();
    send_frame();
    idle(10);
    vectors++;
    if (outq.size() != 5) begin
      miscompares++;
      $display("FAIL short_count: got %0d bits want 5", outq.size());
    end
    for (int i = 0; i < expq.size() && i < outq.size(); i++) begin
      vectors++;
      if (outq[i] !== expq[i]) begin
        miscompares++;
        $display("FAIL short_bit[%0d]: got %0d want %0d", i, outq[i], expq[i]);
      end
    end
    vectors++;
    if (busy_cnt != 5) begin
      miscompares++;
      $display("FAIL short_busy_cycles: got %0d want 5", busy_cnt);
    end
    first = (out_cyc.size() > 0) ? out_cyc[0] : -1;
    vectors++;
    if (first != sym_cyc[4] + 3) begin
      miscompares++;
      $display("FAIL short_first_cycle: got %0d want %0d", first, sym_cyc[4] + 3);
    end
  endtask

  task automatic test_reset_mid_run();
    clear_capture();
    make_payload(10, 2);
    encode();
    send_frame();
    rst_n = 1'b0; sym_valid = 1'b1; sym = 2'b11;
    @(posedge clk);
    #1;
    vectors++;
    if (io_out[2:1] !== 2'b00) begin
      miscompares++;
      $display("FAIL midreset_flags: busy,valid got %b want 00", io_out[2:1]);
    end
    rst_n = 1'b1; sym_valid = 1'b0;
    idle(DEPTH + 8);
    vectors++;
    if (outq.size() != 0) begin
      miscompares++;
      $display("FAIL midreset_stale: got %0d bits after reset want 0", outq.size());
    end
    clear_capture();
    make_payload(20, 1);
    encode();
    send_frame();
    idle(DEPTH + 6);
    vectors++;
    if (outq.size() != 20) begin
      miscompares++;
      $display("FAIL midreset_count: got %0d bits want 20", outq.size());
    end
    for (int i = 0; i < expq.size() && i < outq.size(); i++) begin
      vectors++;
      if (outq[i] !== expq[i]) begin
        miscompares++;
        $display("FAIL midreset_bit[%0d]: got %0d want %0d", i, outq[i], expq[i]);
      end
    end
  endtask

  task automatic test_back_to_back();
    clear_capture();
    make_payload(30, 0);
    encode();
    send_frame();
    idle(DEPTH + 1);
    make_payload(24, 0);
    encode();
    send_frame();
    idle(DEPTH + 8);
    vectors++;
    if (outq.size() != 54) begin
      miscompares++;
      $display("FAIL b2b_count: got %0d bits want 54", outq.size());
    end
    for (int i = 0; i < expq.size() && i < outq.size(); i++) begin
      vectors++;
      if (outq[i] !== expq[i]) begin
        miscompares++;
        $display("FAIL b2b_bit[%0d]: got %0d want %0d", i, outq[i], expq[i]);
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached before the end of the run");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; sym_valid = 1'b0; sym = 2'b00; junk = 3'b000;
    test_reset();
    test_all_zero();
    test_impulse(1'b0);
    test_impulse(1'b1);
    test_random();
    test_short_frame();
    test_reset_mid_run();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
